// File: rtl/dmem_responder.sv
// Single-port data memory responder: RISC-V byte/half/word loads and stores behind a
// valid/ready request/response handshake. Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          NB       = DATA_WIDTH / 8;
  localparam logic [3:0]  CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    mem_rd_q;

  logic                     acc_go;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  logic a_err;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    acc_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            acc_go  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The error flag is captured with the access and cleared when leaving RESP.
    if (acc_go) begin
      err_d = a_err;
    end else if (state_d == IDLE) begin
      err_d = 1'b0;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

  // ---------------------------------------------------------------------------
  // Access decode. With zero wait states the access happens on the accept edge,
  // so the request inputs are decoded directly instead of the latched copies.
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic                     a_we;
  logic [2:0]               a_f3;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic [1:0]               a_size;
  logic                     a_f3_ok;
  logic                     a_in_range;
  logic                     a_misalign;
  logic [1:0]               a_off;
  logic [ADDRESS_WIDTH-3:0] a_word;
  logic [IDX_W-1:0]         mem_idx;
  logic                     mem_we;

  always_comb begin
    a_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    a_we    = (state_q == IDLE) ? req_we     : we_q;
    a_f3    = (state_q == IDLE) ? req_funct3 : funct3_q;
    a_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    a_size  = a_f3[1:0];
    if (a_we) begin
      a_f3_ok = (a_f3 == 3'b000) || (a_f3 == 3'b001) || (a_f3 == 3'b010);
    end else begin
      a_f3_ok = (a_f3 == 3'b000) || (a_f3 == 3'b001) || (a_f3 == 3'b010) ||
                (a_f3 == 3'b100) || (a_f3 == 3'b101);
    end
    a_word     = a_addr[ADDRESS_WIDTH-1:2];
    a_in_range = ((a_word >> IDX_W) == '0);
    mem_idx    = a_word[IDX_W-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    a_misalign = ((a_size == 2'b01) && a_addr[0]) ||
                 ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    a_misalign = 1'b0;
`endif
    a_err = !a_f3_ok || !a_in_range || a_misalign;
    // Without trapping, halfword/word addresses are forced to natural alignment.
    case (a_size)
      2'b00:   a_off = a_addr[1:0];
      2'b01:   a_off = {a_addr[1], 1'b0};
      default: a_off = 2'b00;
    endcase
    mem_we = acc_go && a_we && !a_err && rst;
  end

  // Store lanes: replicate the right-aligned data and enable only addressed bytes.
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      localparam int         HLO  = (gi % 2) * 8;
      always_comb begin
        case (a_size)
          2'b00: begin
            wr_data[gi*8 +: 8] = a_wdata[7:0];
            wr_be[gi]          = (a_off == LANE);
          end
          2'b01: begin
            wr_data[gi*8 +: 8] = a_wdata[HLO +: 8];
            wr_be[gi]          = (a_off[1] == LANE[1]);
          end
          default: begin
            wr_data[gi*8 +: 8] = a_wdata[gi*8 +: 8];
            wr_be[gi]          = 1'b1;
          end
        endcase
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage: not reset, registered read captured on the edge entering RESP.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (acc_go) begin
      mem_rd_q <= mem[mem_idx];
    end
    for (int i = 0; i < NB; i++) begin
      if (mem_we && wr_be[i]) begin
        mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the held read word and latched request fields.
  // ---------------------------------------------------------------------------
  logic [1:0]            ld_off;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ld_off = addr_q[1:0];
      2'b01:   ld_off = {addr_q[1], 1'b0};
      default: ld_off = 2'b00;
    endcase
    ld_shift = mem_rd_q >> {ld_off, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_ext = ld_shift;
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
      default: ld_ext = '0;
    endcase
    rsp_rdata = (state_q == RESP && !we_q && !err_q) ? ld_ext : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and one with none,
// sharing every input so the same transaction is checked on both.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One request through both instances; the response is held for 'hold' extra cycles.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      input logic [31:0] exp_rd1, input logic [31:0] exp_rd0,
                      input logic exp_err);
    int edges;
    int e1;
    int e0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    edges = 1;
    e1 = 0;
    e0 = 0;
    @(negedge clk);
    if (rsp_valid1 && e1 == 0) e1 = edges;
    if (rsp_valid0 && e0 == 0) e0 = edges;
    // A harmless-looking store offered while busy must be ignored.
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h5555_5555;
    while (!(rsp_valid1 && rsp_valid0) && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (rsp_valid1 && e1 == 0) e1 = edges;
      if (rsp_valid0 && e0 == 0) e0 = edges;
    end
    req_valid = 1'b0;
    check({tag, ".lat1"}, e1, 2);
    check({tag, ".lat0"}, e0, 1);
    check({tag, ".rd1"}, rsp_rdata1, exp_rd1);
    check({tag, ".err1"}, rsp_err1, exp_err);
    check({tag, ".rd0"}, rsp_rdata0, exp_rd0);
    check({tag, ".err0"}, rsp_err0, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_v"}, rsp_valid1, 1'b1);
      check({tag, ".hold_rd"}, rsp_rdata1, exp_rd1);
      check({tag, ".hold_err"}, rsp_err1, exp_err);
      check({tag, ".hold_rdy"}, req_ready1, 1'b0);
    end
    $display("[TB] %s we=%0d f3=%0b addr=%h wdata=%h -> rd1=%h rd0=%h err=%0d lat=%0d/%0d",
             tag, we, f3, addr, wd, rsp_rdata1, rsp_rdata0, rsp_err1, e1, e0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".idle1"}, req_ready1, 1'b1);
    check({tag, ".idle0"}, req_ready0, 1'b1);
    check({tag, ".done_v"}, rsp_valid1, 1'b0);
  endtask

  logic [31:0] lh11_rd, lw12_rd;
  logic        mis_err;

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    lh11_rd = 32'h0;
    lw12_rd = 32'h0;
    mis_err = 1'b1;
`else
    lh11_rd = 32'hFFFF_8001;
    lw12_rd = 32'h8000_8001;
    mis_err = 1'b0;
`endif
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    #2;
    check("rst.valid", rsp_valid1, 1'b0);
    check("rst.rdata", rsp_rdata1, 32'h0);
    check("rst.err", rsp_err1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.ready", req_ready1, 1'b1);

    xact("sw10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 1'b0);
    xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    xact("sw10z", 1'b1, 3'b010, 32'h10, 32'h0, 0, 32'h0, 32'h0, 1'b0);
    xact("sb13",  1'b1, 3'b000, 32'h13, 32'hAAAA_AA80, 0, 32'h0, 32'h0, 1'b0);
    xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFF_FF80, 32'hFFFF_FF80, 1'b0);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, 32'h0000_0080, 32'h0000_0080, 1'b0);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    xact("sh10",  1'b1, 3'b001, 32'h10, 32'h1234_8001, 0, 32'h0, 32'h0, 1'b0);
    xact("lh11",  1'b0, 3'b001, 32'h11, 32'h0, 0, lh11_rd, lh11_rd, mis_err);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 0, 32'h0000_8000, 32'h0000_8000, 1'b0);
    xact("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 0, lw12_rd, lw12_rd, mis_err);
    xact("sw0",   1'b1, 3'b010, 32'h0, 32'h0BAD_F00D, 0, 32'h0, 32'h0, 1'b0);
    xact("sw1000", 1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1'b1);
    xact("lw0a",  1'b0, 3'b010, 32'h0, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    xact("ld011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
    xact("ld110", 1'b0, 3'b110, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
    xact("st011", 1'b1, 3'b011, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1'b1);
    xact("lw0b",  1'b0, 3'b010, 32'h0, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    xact("stall", 1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h8000_8001, 32'h8000_8001, 1'b0);
    xact("sw20",  1'b1, 3'b010, 32'h20, 32'h1234_5678, 0, 32'h0, 32'h0, 1'b0);

    // Reset during the wait state of a store: the waiting instance must drop it.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstw.pre_v1", rsp_valid1, 1'b0);
    check("rstw.pre_v0", rsp_valid0, 1'b1);
    rst = 1'b0;
    #1;
    check("rstw.v1", rsp_valid1, 1'b0);
    check("rstw.v0", rsp_valid0, 1'b0);
    check("rstw.err1", rsp_err1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw.ready1", req_ready1, 1'b1);
    $display("[TB] rstw reset pulsed during WAIT of SW 0x20");
    xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
